// File: rtl/ram_burst_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_burst_pkg
// Description : Shared types and elaboration helpers for ram_burst_reader.
//               Holds the FSM state encoding, the credit-counter width
//               helper and the parameter legality checks used by the top.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_burst_pkg;

    // Burst engine states, explicitly encoded on two bits
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Credit/occupancy counters must hold the value FIFO_DEPTH itself
    function automatic int credit_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // RAM read latency supported by the latency pipe
    function automatic bit latency_ok(input int lat);
        return (lat >= 1) && (lat <= 4);
    endfunction

    // FIFO must be a power of two and deep enough to cover a full latency pipe
    function automatic bit depth_ok(input int depth, input int lat);
        return (depth > 0) && ((depth & (depth - 1)) == 0) && (depth >= lat + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_burst_reader_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock first-word-fall-through FIFO. The head entry is
//               presented on o_data whenever o_empty is low. i_flush empties
//               the FIFO synchronously and takes priority over push/pop.
// Ports       : i_clk, i_rst_n (async, active low), i_flush, i_push, i_pop,
//               i_data, o_data, o_full, o_empty, o_count
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (c_PTR_W + 1)'(DEPTH));
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    // A pop request against an empty FIFO is simply ignored
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            // Storage is cleared so the head reads as zero out of reset
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : ram_burst_reader
// Description : Burst-read engine for a single-port synchronous RAM. A single
//               start command (base, length) produces back-to-back reads,
//               throttled by a credit scheme so the output FIFO can never
//               overflow. Returned data leaves on a valid/ready stream in
//               address order.
// Ports       : i_clk, i_rst_n (async, active low)
//               i_start, i_base_addr, i_len, o_busy, o_done  - command side
//               o_rd_en, o_ram_addr, i_data_rd               - RAM side
//               o_data_rd, o_valid, i_ready                  - stream side
//               i_abort, o_aborted        - only with RAM_BURST_ABORT_EN
// Options     : `define RAM_BURST_ABORT_EN adds burst abort support.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_burst_reader
    import ram_burst_pkg::*;
#(
    parameter int SIZE_DATA  = 8,
    parameter int SIZE_ADDR  = 8,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [SIZE_ADDR-1:0] i_base_addr,
    input  logic [SIZE_ADDR-1:0] i_len,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_rd_en,
    output logic [SIZE_ADDR-1:0] o_ram_addr,
    input  logic [SIZE_DATA-1:0] i_data_rd,
    output logic [SIZE_DATA-1:0] o_data_rd,
    output logic                 o_valid,
    input  logic                 i_ready
`ifdef RAM_BURST_ABORT_EN
    ,
    input  logic                 i_abort,
    output logic                 o_aborted
`endif
);

    localparam int                 c_CNT_W = credit_width(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);

    generate
        if (!latency_ok(RD_LATENCY)) begin : g_bad_latency
            $error("ram_burst_reader: RD_LATENCY must be within 1..4");
        end
        if (!depth_ok(FIFO_DEPTH, RD_LATENCY)) begin : g_bad_depth
            $error("ram_burst_reader: FIFO_DEPTH must be a power of 2 and >= RD_LATENCY+1");
        end
    endgenerate

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SIZE_ADDR-1:0]  r_addr;
    logic [SIZE_ADDR-1:0]  r_remain;
    logic [RD_LATENCY-1:0] r_pipe;
    logic [c_CNT_W-1:0]    r_in_flight;
    logic                  r_zero_done;

    logic                  w_accept;
    logic                  w_issue;
    logic                  w_exit;
    logic                  w_push;
    logic                  w_flush;
    logic                  w_abort;
    logic                  w_drain_done;
    logic                  w_fifo_empty;
    logic                  w_fifo_full;
    logic [c_CNT_W-1:0]    w_fifo_count;
    logic [c_CNT_W-1:0]    w_credits;

    // Every issued read owns a FIFO slot until it is popped, so the sum of
    // occupancy and reads in flight never exceeds the depth.
    assign w_credits    = c_DEPTH - w_fifo_count - r_in_flight;
    assign w_exit       = r_pipe[RD_LATENCY-1];
    assign w_accept     = (r_state == IDLE) && i_start && (i_len != '0);
    assign w_drain_done = (r_state == DRAIN) && (r_in_flight == '0) && w_fifo_empty;

    assign o_done     = r_zero_done | w_drain_done;
    assign o_busy     = (r_state != IDLE) && !w_drain_done;
    assign o_rd_en    = w_issue;
    assign o_ram_addr = r_addr;
    assign o_valid    = !w_fifo_empty;

`ifdef RAM_BURST_ABORT_EN
    logic r_aborting;

    // Abort is only meaningful while a burst is running
    assign w_abort   = i_abort && o_busy;
    assign w_flush   = w_abort;
    // Returns belonging to an aborted burst are discarded on arrival
    assign w_push    = w_exit && !w_abort && !r_aborting;
    assign o_aborted = w_drain_done && r_aborting;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_aborting <= 1'b0;
        end else if (w_drain_done) begin
            r_aborting <= 1'b0;
        end else if (w_abort) begin
            r_aborting <= 1'b1;
        end
    end
`else
    assign w_abort = 1'b0;
    assign w_flush = 1'b0;
    assign w_push  = w_exit;
`endif

    // Next-state and issue decision
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (w_abort) begin
                    w_state_nxt = DRAIN;
                end else if (w_credits != '0) begin
                    w_issue = 1'b1;
                    if (r_remain == SIZE_ADDR'(1)) begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (w_drain_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_remain    <= '0;
            r_pipe      <= '0;
            r_in_flight <= '0;
            r_zero_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            // A zero-length request completes immediately without any read
            r_zero_done <= (r_state == IDLE) && i_start && (i_len == '0);

            if (w_accept) begin
                r_addr   <= i_base_addr;
                r_remain <= i_len;
            end else if (w_issue) begin
                // Address wraps naturally at 2^SIZE_ADDR
                r_addr   <= r_addr + SIZE_ADDR'(1);
                r_remain <= r_remain - SIZE_ADDR'(1);
            end

            // Valid bit travels alongside the RAM read; it leaves exactly when
            // the matching i_data_rd is valid.
            r_pipe[0] <= w_issue;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end

            r_in_flight <= r_in_flight + c_CNT_W'(w_issue) - c_CNT_W'(w_exit);
        end
    end

    sync_fifo #(
        .WIDTH (SIZE_DATA),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_pop   (i_ready),
        .i_data  (i_data_rd),
        .o_data  (o_data_rd),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

`ifndef SYNTHESIS
    // The credit scheme must make a push into a full FIFO impossible
    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(w_push && w_fifo_full));
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_burst_reader
// Description : Directed self-checking bench for ram_burst_reader with a
//               behavioural RAM (mem[a] = a ^ 8'hA5) of latency RD_LAT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_burst_reader;

    localparam int RD_LAT = 3;
    localparam int DEPTH  = 4;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_start;
    logic [7:0] i_base_addr;
    logic [7:0] i_len;
    logic       o_busy;
    logic       o_done;
    logic       o_rd_en;
    logic [7:0] o_ram_addr;
    logic [7:0] i_data_rd;
    logic [7:0] o_data_rd;
    logic       o_valid;
    logic       i_ready;
    logic       i_abort;
    logic       aborted_sig;

    ram_burst_reader #(
        .SIZE_DATA  (8),
        .SIZE_ADDR  (8),
        .RD_LATENCY (RD_LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_len       (i_len),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_rd_en     (o_rd_en),
        .o_ram_addr  (o_ram_addr),
        .i_data_rd   (i_data_rd),
        .o_data_rd   (o_data_rd),
        .o_valid     (o_valid),
        .i_ready     (i_ready)
`ifdef RAM_BURST_ABORT_EN
        ,
        .i_abort     (i_abort),
        .o_aborted   (aborted_sig)
`endif
    );

`ifndef RAM_BURST_ABORT_EN
    assign aborted_sig = 1'b0;
`endif

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Behavioural RAM: address sampled on the rising edge, data RD_LAT cycles later
    logic [7:0] ram_pipe [RD_LAT];
    always @(posedge i_clk) begin
        for (int i = RD_LAT - 1; i > 0; i--) ram_pipe[i] <= ram_pipe[i-1];
        ram_pipe[0] <= o_ram_addr ^ 8'hA5;
    end
    assign i_data_rd = ram_pipe[RD_LAT-1];

    int         cyc = 0;
    int         n_pass = 0;
    int         n_total = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    logic       done_ab = 1'b0;
    int         rd_cnt = 0;
    int         outstanding = 0;
    logic       overissue = 1'b0;
    logic [7:0] got [$];
    int         hs_cyc [$];
    logic [7:0] addr_q [$];
    logic [7:0] exp_q [$];

    always @(posedge i_clk) cyc++;

    // Observation on the falling edge, away from the active edge
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            outstanding = 0;
        end else begin
            if (o_rd_en) begin
                // Issued-but-not-popped words may never exceed the FIFO depth
                if (outstanding >= DEPTH) overissue = 1'b1;
                addr_q.push_back(o_ram_addr);
                rd_cnt++;
            end
            if (o_valid && i_ready) begin
                got.push_back(o_data_rd);
                hs_cyc.push_back(cyc);
            end
            outstanding = outstanding + int'(o_rd_en) - int'(o_valid && i_ready);
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
                done_ab  = aborted_sig;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic start_burst(input logic [7:0] b, input logic [7:0] l, output int s);
        i_start = 1'b1; i_base_addr = b; i_len = l;
        tick();
        i_start = 1'b0;
        s = cyc;
    endtask

    task automatic wait_done(input int d0, input bit toggle);
        for (int i = 0; i < 300 && done_cnt == d0; i++) begin
            tick();
            if (toggle) i_ready = ~i_ready;
        end
        check("done_seen", done_cnt, d0 + 1);
    endtask

    task automatic check_words(input string tag);
        check({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check(tag, (i < got.size()) ? {24'd0, got[i]} : 32'hDEAD, {24'd0, exp_q[i]});
        end
    endtask

    task automatic clear_logs();
        got.delete(); hs_cyc.delete(); addr_q.delete();
    endtask

    initial begin
        int s;
        int d0;
        int r0;
        i_rst_n = 1'b0; i_start = 1'b0; i_base_addr = '0; i_len = '0;
        i_ready = 1'b1; i_abort = 1'b0;
        #2;
        check("rst_busy",  o_busy,  0);
        check("rst_done",  o_done,  0);
        check("rst_rd_en", o_rd_en, 0);
        check("rst_valid", o_valid, 0);
        check("rst_addr",  o_ram_addr, 0);
        check("rst_data",  o_data_rd,  0);
        tick();
        i_rst_n = 1'b1;
        tick();

        // Base 0x10, len 4, consumer always ready
        clear_logs(); d0 = done_cnt;
        start_burst(8'h10, 8'd4, s);
        @(negedge i_clk);
        check("b1_busy",  o_busy, 1);
        check("b1_rd_en", o_rd_en, 1);
        check("b1_addr0", o_ram_addr, 8'h10);
        wait_done(d0, 1'b0);
        exp_q = '{8'hB5, 8'hB4, 8'hB7, 8'hB6};
        check_words("b1_data");
        check("b1_first_valid", (hs_cyc.size() > 0) ? hs_cyc[0] : -1, s + RD_LAT + 1);
        check("b1_last_hs",     (hs_cyc.size() > 3) ? hs_cyc[3] : -1, s + RD_LAT + 4);
        check("b1_done_cyc",    done_cyc, s + RD_LAT + 5);

        // Address wrap FE -> 01
        clear_logs(); d0 = done_cnt;
        start_burst(8'hFE, 8'd4, s);
        wait_done(d0, 1'b0);
        exp_q = '{8'h5B, 8'h5A, 8'hA5, 8'hA4};
        check_words("wrap_data");
        check("wrap_addr_cnt", addr_q.size(), 4);
        check("wrap_addr2", (addr_q.size() > 2) ? {24'd0, addr_q[2]} : 32'hDEAD, 32'h00);
        check("wrap_addr3", (addr_q.size() > 3) ? {24'd0, addr_q[3]} : 32'hDEAD, 32'h01);

        // Ready toggling every cycle, len 8
        clear_logs(); d0 = done_cnt;
        i_ready = 1'b0;
        start_burst(8'h20, 8'd8, s);
        wait_done(d0, 1'b1);
        i_ready = 1'b1;
        exp_q = '{8'h85, 8'h84, 8'h87, 8'h86, 8'h81, 8'h80, 8'h83, 8'h82};
        check_words("tog_data");
        tick();

        // Zero-length request
        r0 = rd_cnt; d0 = done_cnt;
        start_burst(8'h33, 8'd0, s);
        @(negedge i_clk);
        check("zl_done", o_done, 1);
        check("zl_busy", o_busy, 0);
        @(negedge i_clk);
        check("zl_done_off", o_done, 0);
        check("zl_no_reads", rd_cnt - r0, 0);
        check("zl_done_cnt", done_cnt, d0 + 1);
        tick();

        // Start while busy is ignored
        clear_logs(); r0 = rd_cnt; d0 = done_cnt;
        start_burst(8'h40, 8'd2, s);
        tick(); tick();
        i_start = 1'b1; i_base_addr = 8'h80; i_len = 8'd3;
        tick();
        i_start = 1'b0;
        wait_done(d0, 1'b0);
        repeat (10) tick();
        exp_q = '{8'hE5, 8'hE4};
        check_words("busy_ign");
        check("busy_ign_reads", rd_cnt - r0, 2);
        check("busy_ign_done",  done_cnt, d0 + 1);

        check("no_overissue", overissue, 0);

        // Reset in the middle of a len-6 burst
        clear_logs(); d0 = done_cnt;
        start_burst(8'h30, 8'd6, s);
        for (int i = 0; i < 100 && got.size() < 2; i++) tick();
        check("mid_hs2", got.size(), 2);
        i_rst_n = 1'b0;
        #1;
        check("mid_busy",  o_busy,  0);
        check("mid_done",  o_done,  0);
        check("mid_rd_en", o_rd_en, 0);
        check("mid_valid", o_valid, 0);
        check("mid_addr",  o_ram_addr, 0);
        tick();
        i_rst_n = 1'b1;
        tick();
        check("mid_no_done", done_cnt, d0);
        clear_logs(); d0 = done_cnt;
        start_burst(8'h00, 8'd2, s);
        wait_done(d0, 1'b0);
        exp_q = '{8'hA5, 8'hA4};
        check_words("post_rst");

`ifdef RAM_BURST_ABORT_EN
        // Abort after the third handshake of a len-8 burst
        tick();
        clear_logs(); d0 = done_cnt;
        start_burst(8'h50, 8'd8, s);
        for (int i = 0; i < 100 && got.size() < 3; i++) tick();
        i_abort = 1'b1; i_ready = 1'b0;
        tick();
        i_abort = 1'b0;
        @(negedge i_clk);
        check("ab_valid_low", o_valid, 0);
        wait_done(d0, 1'b0);
        check("ab_aborted", done_ab, 1);
        exp_q = '{8'hF5, 8'hF4, 8'hF7};
        check_words("ab_data");
        i_ready = 1'b1;
        repeat (5) tick();
        check("ab_idle", o_busy, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
